adc_spi_capture: RTL and testbench

- Front end for the dual-channel 12-bit SPI ADC (two converters sharing cs_n and sclk, separate data lines).
- Runs continuous conversion frames and shifts both channels in parallel.
- Converts offset-binary to two's complement and presents the sample pair with a one-cycle ready strobe.
- Its outputs drive the ADC controller's dataInChannel1/2 and inputReady inputs.

---
 rtl/adc_spi_capture_if.sv | 36 +++
 rtl/adc_spi_capture.sv | 136 +++++++++++++
 tb/tb_adc_spi_capture.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/adc_spi_capture_if.sv
// Bundle between the dual-channel SPI ADC front end and its consumers.
// Compile with ADC_SPI_CAPTURE_ZERO_CHECK_EN to carry the frameError flag.
interface adc_spi_capture_if #(
    parameter int IO_BITS = 12
);
    logic                      enable;
    logic                      miso1;
    logic                      miso2;
    logic                      cs_n;
    logic                      sclk;
    logic signed [IO_BITS-1:0] dataOutChannel1;
    logic signed [IO_BITS-1:0] dataOutChannel2;
    logic                      outputReady;
    logic                      busy;
`ifdef ADC_SPI_CAPTURE_ZERO_CHECK_EN
    logic                      frameError;

    modport master (
        input  enable, miso1, miso2,
        output cs_n, sclk, dataOutChannel1, dataOutChannel2, outputReady, busy, frameError
    );
    modport slave (
        output enable, miso1, miso2,
        input  cs_n, sclk, dataOutChannel1, dataOutChannel2, outputReady, busy, frameError
    );
`else
    modport master (
        input  enable, miso1, miso2,
        output cs_n, sclk, dataOutChannel1, dataOutChannel2, outputReady, busy
    );
    modport slave (
        output enable, miso1, miso2,
        input  cs_n, sclk, dataOutChannel1, dataOutChannel2, outputReady, busy
    );
`endif
endinterface

// File: rtl/adc_spi_capture.sv
// Continuous-frame capture of two SPI ADC channels, offset-binary to two's complement.
// Optional ADC_SPI_CAPTURE_ZERO_CHECK_EN flags frames whose leading bits are not zero.
module adc_spi_capture #(
    parameter int IO_BITS       = 12,
    parameter int FRAME_BITS    = 16,
    parameter int LEADING_ZEROS = 4,
    parameter int CLOCK_DIVIDER = 4,
    parameter int QUIET_CYCLES  = 8,
    parameter int INPUT_OFFSET  = 2048
) (
    input logic              clock,
    input logic              reset,
    adc_spi_capture_if.master bus
);
    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam int DW = $clog2(CLOCK_DIVIDER + 1);
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam int CW = IO_BITS + 2;

    localparam int MAX_I = (1 << (IO_BITS - 1)) - 1;
    localparam int MIN_I = -MAX_I - 1;
    localparam logic signed [CW-1:0] SAT_MAX    = MAX_I[CW-1:0];
    localparam logic signed [CW-1:0] SAT_MIN    = MIN_I[CW-1:0];
    localparam logic signed [CW-1:0] OFFSET_EXT = INPUT_OFFSET[CW-1:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        QUIET = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    logic [QW-1:0]         quiet_cnt;
    logic [DW-1:0]         div_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [FRAME_BITS-1:0] sr1;
    logic [FRAME_BITS-1:0] sr2;

    // Subtract in a wider signed domain so any offset saturates instead of wrapping.
    function automatic logic signed [IO_BITS-1:0] convert(input logic [FRAME_BITS-1:0] sr);
        logic signed [CW-1:0] diff;
        diff = $signed({2'b00, sr[IO_BITS-1:0]}) - OFFSET_EXT;
        if (diff > SAT_MAX)
            return SAT_MAX[IO_BITS-1:0];
        else if (diff < SAT_MIN)
            return SAT_MIN[IO_BITS-1:0];
        else
            return diff[IO_BITS-1:0];
    endfunction

`ifdef ADC_SPI_CAPTURE_ZERO_CHECK_EN
    logic leading_set;
    assign leading_set = (|sr1[FRAME_BITS-1 -: LEADING_ZEROS]) |
                         (|sr2[FRAME_BITS-1 -: LEADING_ZEROS]);
`else
    logic unused_leading;
    assign unused_leading = ^{sr1[FRAME_BITS-1 -: LEADING_ZEROS],
                              sr2[FRAME_BITS-1 -: LEADING_ZEROS]};
`endif

    assign bus.busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state               <= IDLE;
            quiet_cnt           <= '0;
            div_cnt             <= '0;
            bit_cnt             <= '0;
            sr1                 <= '0;
            sr2                 <= '0;
            bus.cs_n            <= 1'b1;
            bus.sclk            <= 1'b1;
            bus.outputReady     <= 1'b0;
            bus.dataOutChannel1 <= '0;
            bus.dataOutChannel2 <= '0;
`ifdef ADC_SPI_CAPTURE_ZERO_CHECK_EN
            bus.frameError      <= 1'b0;
`endif
        end else begin
            bus.outputReady <= 1'b0;
`ifdef ADC_SPI_CAPTURE_ZERO_CHECK_EN
            bus.frameError  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        state     <= QUIET;
                        quiet_cnt <= '0;
                    end
                end
                QUIET: begin
                    if (!bus.enable) begin
                        state <= IDLE;
                    end else if (quiet_cnt == QW'(QUIET_CYCLES - 1)) begin
                        state    <= SHIFT;
                        bus.cs_n <= 1'b0;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                    end else begin
                        quiet_cnt <= quiet_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_cnt == DW'(CLOCK_DIVIDER - 1)) begin
                        div_cnt  <= '0;
                        bus.sclk <= ~bus.sclk;
                        // sclk currently low means this toggle is the rising sample edge.
                        if (!bus.sclk) begin
                            sr1     <= {sr1[FRAME_BITS-2:0], bus.miso1};
                            sr2     <= {sr2[FRAME_BITS-2:0], bus.miso2};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == BW'(FRAME_BITS - 1)) begin
                                state    <= DONE;
                                bus.cs_n <= 1'b1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE: begin
                    bus.dataOutChannel1 <= convert(sr1);
                    bus.dataOutChannel2 <= convert(sr2);
                    bus.outputReady     <= 1'b1;
`ifdef ADC_SPI_CAPTURE_ZERO_CHECK_EN
                    bus.frameError      <= leading_set;
`endif
                    quiet_cnt <= '0;
                    state     <= bus.enable ? QUIET : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_spi_capture.sv
// Directed bench for adc_spi_capture with CLOCK_DIVIDER=2, QUIET_CYCLES=3.
// A behavioural ADC launches each frame word MSB first on falling sclk.
module tb_adc_spi_capture;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    adc_spi_capture_if #(.IO_BITS(12)) bus ();

    adc_spi_capture #(
        .CLOCK_DIVIDER(2),
        .QUIET_CYCLES (3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // ADC model
    logic [15:0] word1, word2, tx1, tx2;
    int          idx = 0;
    always @(negedge bus.cs_n) begin
        tx1 = word1;
        tx2 = word2;
        idx = 16;
    end
    always @(negedge bus.sclk) begin
        if (bus.cs_n === 1'b0 && idx > 0) begin
            idx       = idx - 1;
            bus.miso1 = tx1[idx];
            bus.miso2 = tx2[idx];
        end
    end

    // sclk edge monitor, sampled 2 time units after each clock edge
    int   cyc = 0, rise_cnt = 0, gap_err = 0, toggles = 0, last_rise = 0;
    logic sclk_prev = 1'b1;
    always @(posedge clock) begin
        cyc = cyc + 1;
        #2;
        if (bus.sclk !== sclk_prev) toggles = toggles + 1;
        if (bus.sclk === 1'b1 && sclk_prev === 1'b0) begin
            if (rise_cnt > 0 && cyc - last_rise != 4) gap_err = gap_err + 1;
            rise_cnt  = rise_cnt + 1;
            last_rise = cyc;
        end
        sclk_prev = bus.sclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] d1();
        return {20'd0, bus.dataOutChannel1};
    endfunction
    function automatic logic [31:0] d2();
        return {20'd0, bus.dataOutChannel2};
    endfunction

    task automatic wait_ready(output int n, input int limit);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus.outputReady !== 1'b1 && n < limit);
    endtask

    int          n, hold_err, cs_err, ready_cnt;
    logic [11:0] hold1, hold2;

    initial begin
        bus.enable = 1'b1;
        bus.miso1  = 1'b0;
        bus.miso2  = 1'b0;
        word1      = 16'h0FFF;
        word2      = 16'h0000;

        // Reset state
        repeat (5) @(negedge clock);
        check("rst_cs_n", bus.cs_n, 1);
        check("rst_sclk", bus.sclk, 1);
        check("rst_ready", bus.outputReady, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_data1", d1(), 0);
        check("rst_data2", d2(), 0);

        // First frame: 0FFF / 0000
        reset = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus.cs_n !== 1'b0 && n < 20);
        check("cs_fall_delay", n, 4);
        check("busy_in_frame", bus.busy, 1);
        rise_cnt = 0;
        gap_err  = 0;
        wait_ready(n, 200);
        check("ready_latency", n, 65);
        check("rise_count1", rise_cnt, 16);
        check("rise_spacing", gap_err, 0);
        check("data1_max", d1(), 32'h7FF);
        check("data2_min", d2(), 32'h800);

        // Second frame: 0800 / 07FF, data held until next strobe
        word1    = 16'h0800;
        word2    = 16'h07FF;
        hold1    = bus.dataOutChannel1;
        hold2    = bus.dataOutChannel2;
        rise_cnt = 0;
        @(negedge clock);
        check("ready_one_cycle", bus.outputReady, 0);
        n = 1;
        hold_err = 0;
        do begin
            @(negedge clock);
            n++;
            if (bus.outputReady !== 1'b1 &&
                (bus.dataOutChannel1 !== hold1 || bus.dataOutChannel2 !== hold2))
                hold_err++;
        end while (bus.outputReady !== 1'b1 && n < 200);
        check("frame_period", n, 68);
        check("data_hold", hold_err, 0);
        check("rise_count2", rise_cnt, 16);
        check("data1_zero", d1(), 0);
        check("data2_minus1", d2(), 32'hFFF);

        // Enable dropped at the 5th rising edge: frame completes then stops
        word1    = 16'h0123;
        word2    = 16'h0ABC;
        rise_cnt = 0;
        n = 0;
        while (rise_cnt < 5 && n < 200) begin
            @(negedge clock);
            n++;
        end
        bus.enable = 1'b0;
        check("en_drop_edge", rise_cnt, 5);
        wait_ready(n, 200);
        check("en_drop_ready", bus.outputReady, 1);
        check("en_drop_rises", rise_cnt, 16);
        check("en_drop_data1", d1(), 32'h923);
        check("en_drop_data2", d2(), 32'h2BC);
        check("en_drop_busy", bus.busy, 0);
        toggles   = 0;
        ready_cnt = 0;
        cs_err    = 0;
        repeat (30) begin
            @(negedge clock);
            if (bus.outputReady === 1'b1) ready_cnt++;
            if (bus.cs_n !== 1'b1 || bus.busy !== 1'b0) cs_err++;
        end
        check("idle_no_toggle", toggles, 0);
        check("idle_no_ready", ready_cnt, 0);
        check("idle_cs_busy", cs_err, 0);

        // Reset at the 8th rising edge aborts the frame
        word1      = 16'h0FFF;
        word2      = 16'h0000;
        bus.enable = 1'b1;
        rise_cnt   = 0;
        n = 0;
        while (rise_cnt < 8 && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("abort_edge", rise_cnt, 8);
        reset = 1'b0;
        @(negedge clock);
        check("abort_cs_n", bus.cs_n, 1);
        check("abort_sclk", bus.sclk, 1);
        check("abort_data1", d1(), 0);
        check("abort_data2", d2(), 0);
        check("abort_ready", bus.outputReady, 0);
        check("abort_busy", bus.busy, 0);
        ready_cnt = 0;
        repeat (3) begin
            @(negedge clock);
            if (bus.outputReady === 1'b1) ready_cnt++;
        end
        check("abort_no_ready", ready_cnt, 0);

        // Recovery frame with a nonzero leading bit on channel 2
        word2 = 16'h4000;
        reset = 1'b1;
        wait_ready(n, 300);
        check("recover_ready", bus.outputReady, 1);
        check("recover_data1", d1(), 32'h7FF);
        check("recover_data2", d2(), 32'h800);
`ifdef ADC_SPI_CAPTURE_ZERO_CHECK_EN
        check("zero_check_set", bus.frameError, 1);
        word2 = 16'h0000;
        @(negedge clock);
        check("zero_check_pulse", bus.frameError, 0);
        wait_ready(n, 300);
        check("zero_check_ready", bus.outputReady, 1);
        check("zero_check_clear", bus.frameError, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
